// File: rtl/quad_step_pkg.sv
// Shared types and the quadrature transition classifier for quad_step_decoder.
package quad_step_pkg;

    // Encodings equal the raw {A,B} pin pair so a 2-bit sample casts directly.
    typedef enum logic [1:0] {
        PH00 = 2'b00,
        PH10 = 2'b10,
        PH11 = 2'b11,
        PH01 = 2'b01
    } qphase_t;

    typedef enum logic [1:0] {
        MV_NONE,
        MV_UP,
        MV_DOWN,
        MV_ILLEGAL
    } qmove_t;

    // Position of a phase within the up cycle 00->10->11->01.
    function automatic logic [1:0] qphase_ord(qphase_t p);
        case (p)
            PH00:    return 2'd0;
            PH10:    return 2'd1;
            PH11:    return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic qmove_t qdec_move(qphase_t prev, qphase_t cur);
        logic [1:0] d;
        d = qphase_ord(cur) - qphase_ord(prev);
        case (d)
            2'd0:    return MV_NONE;
            2'd1:    return MV_UP;
            2'd3:    return MV_DOWN;
            default: return MV_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// Pin/result bundle between quad_step_decoder and its user.
interface quad_step_decoder_if #(
    parameter int unsigned CNT_W = 16
);
    logic             a_in;
    logic             b_in;
    logic             clr;
    logic             err_clr;
    logic             step_en;
    logic             step_up;
    logic [CNT_W-1:0] pos;
    logic             err;

    modport master (
        output a_in, b_in, clr, err_clr,
        input  step_en, step_up, pos, err
    );

    modport slave (
        input  a_in, b_in, clr, err_clr,
        output step_en, step_up, pos, err
    );
endinterface

// File: rtl/qdec_input_cond.sv
// Synchroniser for one asynchronous encoder pin, plus a stability filter
// when QDEC_GLITCH_FILTER_EN is defined.
module qdec_input_cond #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("qdec_input_cond: SYNC_STAGES must be at least 2");
    end
    if (FILT_CYCLES < 1) begin : g_bad_filt
        $error("qdec_input_cond: FILT_CYCLES must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end

`ifdef QDEC_GLITCH_FILTER_EN
    localparam int unsigned CW = $clog2(FILT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic          filt_q;

    // Counts consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(FILT_CYCLES - 1)) begin
            cnt_q  <= '0;
            filt_q <= sync_q[SYNC_STAGES-1];
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign dout = filt_q;
`else
    assign dout = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: step pulses, direction, wrapping position, sticky error.
// Optional glitch filter on the inputs: define QDEC_GLITCH_FILTER_EN.
module quad_step_decoder
    import quad_step_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 4
) (
    input logic                clk,
    input logic                rst,
    quad_step_decoder_if.slave bus
);

`ifdef QDEC_GLITCH_FILTER_EN
    localparam int unsigned PIPE_CYCLES = SYNC_STAGES + FILT_CYCLES;
`else
    localparam int unsigned PIPE_CYCLES = SYNC_STAGES;
`endif
    localparam int unsigned WW = $clog2(PIPE_CYCLES + 1);

    logic    a_c, b_c;
    qphase_t phase_c;
    qmove_t  move_c;

    qdec_input_cond #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_cond_a (
        .clk(clk), .rst(rst), .din(bus.a_in), .dout(a_c)
    );
    qdec_input_cond #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_cond_b (
        .clk(clk), .rst(rst), .din(bus.b_in), .dout(b_c)
    );

    assign phase_c = qphase_t'({a_c, b_c});

    qphase_t          prev_q, prev_d;
    logic             init_q, init_d;
    logic [WW-1:0]    warm_q, warm_d;
    logic             step_en_q, step_en_d;
    logic             step_up_q, step_up_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic             err_q, err_d;

    // init stays set until the conditioned phase reflects the pins, so a
    // non-zero pin level at reset release is loaded rather than decoded.
    always_comb begin
        prev_d    = phase_c;
        init_d    = init_q;
        warm_d    = warm_q;
        step_en_d = 1'b0;
        step_up_d = step_up_q;
        pos_d     = pos_q;
        err_d     = err_q;
        move_c    = MV_NONE;

        if (bus.err_clr) err_d = 1'b0;

        if (init_q) begin
            init_d = (warm_q < WW'(PIPE_CYCLES));
            if (warm_q < WW'(PIPE_CYCLES)) warm_d = warm_q + WW'(1);
        end else begin
            move_c = qdec_move(prev_q, phase_c);
        end

        case (move_c)
            MV_UP: begin
                step_en_d = 1'b1;
                step_up_d = 1'b1;
                pos_d     = pos_q + CNT_W'(1);
            end
            MV_DOWN: begin
                step_en_d = 1'b1;
                step_up_d = 1'b0;
                pos_d     = pos_q - CNT_W'(1);
            end
            MV_ILLEGAL: err_d = 1'b1;
            default: ;
        endcase

        if (bus.clr) pos_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= PH00;
            init_q    <= 1'b1;
            warm_q    <= '0;
            step_en_q <= 1'b0;
            step_up_q <= 1'b0;
            pos_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            init_q    <= init_d;
            warm_q    <= warm_d;
            step_en_q <= step_en_d;
            step_up_q <= step_up_d;
            pos_q     <= pos_d;
            err_q     <= err_d;
        end
    end

    assign bus.step_en = step_en_q;
    assign bus.step_up = step_up_q;
    assign bus.pos     = pos_q;
    assign bus.err     = err_q;

endmodule
